// File: rtl/mem_access_stage.sv
// MEM stage of the RV64IM(+A) pipeline: loads, stores, LR/SC and AMO read-modify-write.
// Optional misaligned-access trapping is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int RESV_GRAN_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] aluout_i,
  input  logic [63:0] sdata_i,
  input  logic        wen_i,
  input  logic [4:0]  rd_i,
  input  logic        csr_wen_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic        rva_valid_i,
  input  logic [4:0]  funct5_i,
  input  logic        exception_i,
  input  logic [63:0] mcause_i,
  input  logic [63:0] pc_i,
  output logic [63:0] dmem_addr,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [7:0]  dmem_wmask,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  output logic        stall_o,
  output logic        wen_o,
  output logic [4:0]  rd_o,
  output logic [63:0] wdata_o,
  output logic        csr_wen_o,
  output logic [11:0] csr_addr_o,
  output logic [63:0] csr_wdata_o,
  output logic        exception_o,
  output logic [63:0] mcause_o,
  output logic [63:0] pc_o
);

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [1:0] {IDLE, LD_WAIT, AMO_RD, AMO_WR} state_t;

  state_t                   state_q, state_d;
  logic [63:0]              amo_old_q, amo_old_d;
  logic                     resv_valid_q, resv_valid_d;
  logic [63:RESV_GRAN_LOG2] resv_addr_q, resv_addr_d;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] rdata, input logic [2:0] f3,
                                              input logic [2:0] off);
    logic [63:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{56{sh[7]}}, sh[7:0]};
      3'b001:  return {{48{sh[15]}}, sh[15:0]};
      3'b010:  return {{32{sh[31]}}, sh[31:0]};
      3'b100:  return {56'b0, sh[7:0]};
      3'b101:  return {48'b0, sh[15:0]};
      3'b110:  return {32'b0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic is_amo_op(input logic [4:0] f5);
    case (f5)
      F5_SWAP, F5_ADD, F5_XOR, F5_AND, F5_OR,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // Word ops compare 32-bit values; the written result only uses the low lanes.
  function automatic logic [63:0] amo_compute(input logic [4:0] f5, input logic [63:0] a,
                                              input logic [63:0] b, input logic is_word);
    logic signed [63:0] as_v, bs_v;
    logic        [63:0] au_v, bu_v;
    logic               lt_s, lt_u;
    if (is_word) begin
      as_v = {{32{a[31]}}, a[31:0]};
      bs_v = {{32{b[31]}}, b[31:0]};
      au_v = {32'b0, a[31:0]};
      bu_v = {32'b0, b[31:0]};
    end else begin
      as_v = a;
      bs_v = b;
      au_v = a;
      bu_v = b;
    end
    lt_s = as_v < bs_v;
    lt_u = au_v < bu_v;
    case (f5)
      F5_SWAP: return b;
      F5_ADD:  return a + b;
      F5_XOR:  return a ^ b;
      F5_AND:  return a & b;
      F5_OR:   return a | b;
      F5_MIN:  return lt_s ? a : b;
      F5_MAX:  return lt_s ? b : a;
      F5_MINU: return lt_u ? a : b;
      F5_MAXU: return lt_u ? b : a;
      default: return a;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return off[1:0] != 2'b00;
      default: return off != 3'b000;
    endcase
  endfunction
`endif

  logic        is_ld, is_st, is_lr, is_sc, is_amo, misalign, sc_ok;
  logic [2:0]  off;
  logic [7:0]  lane_mask;
  logic [63:0] load_val, amo_res;

  assign off       = aluout_i[2:0];
  assign is_lr     = rva_valid_i && (funct5_i == F5_LR);
  assign is_sc     = rva_valid_i && (funct5_i == F5_SC);
  assign is_amo    = rva_valid_i && is_amo_op(funct5_i);
  assign is_ld     = !rva_valid_i && load_i;
  assign is_st     = !rva_valid_i && store_i;
  assign lane_mask = size_mask(funct3_i[1:0]) << off;
  assign load_val  = load_extend(dmem_rdata, funct3_i, off);
  assign amo_res   = amo_compute(funct5_i, amo_old_q, sdata_i, funct3_i[1:0] == 2'b10);
  assign sc_ok     = resv_valid_q && (resv_addr_q == aluout_i[63:RESV_GRAN_LOG2]);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign  = (is_ld || is_st || is_lr || is_sc || is_amo) &&
                     is_misaligned(funct3_i[1:0], off);
`else
  assign misalign  = 1'b0;
`endif

  assign dmem_addr   = {aluout_i[63:3], 3'b000};
  assign rd_o        = rd_i;
  assign csr_addr_o  = csr_addr_i;
  assign csr_wdata_o = csr_wdata_i;
  assign pc_o        = pc_i;

  always_comb begin
    state_d      = state_q;
    amo_old_d    = amo_old_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    dmem_ren     = 1'b0;
    dmem_wen     = 1'b0;
    dmem_wmask   = lane_mask;
    dmem_wdata   = sdata_i << {off, 3'b000};
    stall_o      = 1'b0;
    wen_o        = 1'b0;
    wdata_o      = aluout_i;
    csr_wen_o    = csr_wen_i;
    exception_o  = exception_i;
    mcause_o     = mcause_i;
    case (state_q)
      IDLE: begin
        if (exception_i) begin
          csr_wen_o    = 1'b0;
          resv_valid_d = 1'b0;
        end else if (misalign) begin
          exception_o  = 1'b1;
          mcause_o     = (is_ld || is_lr) ? 64'd4 : 64'd6;
          csr_wen_o    = 1'b0;
          resv_valid_d = 1'b0;
        end else if (is_ld || is_lr) begin
          dmem_ren = 1'b1;
          stall_o  = 1'b1;
          state_d  = LD_WAIT;
        end else if (is_sc) begin
          resv_valid_d = 1'b0;
          wen_o        = wen_i;
          dmem_wen     = sc_ok;
          wdata_o      = sc_ok ? 64'd0 : 64'd1;
        end else if (is_amo) begin
          dmem_ren = 1'b1;
          stall_o  = 1'b1;
          state_d  = AMO_RD;
        end else if (is_st) begin
          dmem_wen = 1'b1;
        end else begin
          wen_o = wen_i;
        end
      end
      // read data for the request issued last cycle is on dmem_rdata
      LD_WAIT: begin
        wdata_o = load_val;
        wen_o   = wen_i;
        state_d = IDLE;
        if (is_lr) begin
          resv_valid_d = 1'b1;
          resv_addr_d  = aluout_i[63:RESV_GRAN_LOG2];
        end
      end
      AMO_RD: begin
        amo_old_d = load_val;
        stall_o   = 1'b1;
        state_d   = AMO_WR;
      end
      AMO_WR: begin
        dmem_wen   = 1'b1;
        dmem_wdata = amo_res << {off, 3'b000};
        wdata_o    = amo_old_q;
        wen_o      = wen_i;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      dmem_ren = 1'b0;
      dmem_wen = 1'b0;
      stall_o  = 1'b0;
      wen_o    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      resv_valid_q <= 1'b0;
      amo_old_q    <= '0;
    end else begin
      state_q      <= state_d;
      resv_valid_q <= resv_valid_d;
      amo_old_q    <= amo_old_d;
    end
    resv_addr_q <= resv_addr_d;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 1-cycle-latency doubleword memory model.
// Define MEM_MISALIGN_CHECK_EN for both files to exercise the trapping build.
module tb_mem_access_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        load_i, store_i, wen_i, csr_wen_i, rva_valid_i, exception_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i, funct5_i;
  logic [11:0] csr_addr_i;
  logic [63:0] aluout_i, sdata_i, csr_wdata_i, mcause_i, pc_i;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ren, dmem_wen;
  logic [7:0]  dmem_wmask;
  logic        stall_o, wen_o, csr_wen_o, exception_o;
  logic [4:0]  rd_o;
  logic [11:0] csr_addr_o;
  logic [63:0] wdata_o, csr_wdata_o, mcause_o, pc_o;

  int n_cmp = 0;
  int n_fail = 0;

  localparam logic [4:0] LR = 5'b00010, SC = 5'b00011, ADD = 5'b00000;
  localparam logic [4:0] MAX = 5'b10100, SWAP = 5'b00001;

  mem_access_stage dut (
    .clock(clock), .reset(reset), .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
    .aluout_i(aluout_i), .sdata_i(sdata_i), .wen_i(wen_i), .rd_i(rd_i),
    .csr_wen_i(csr_wen_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .rva_valid_i(rva_valid_i), .funct5_i(funct5_i), .exception_i(exception_i),
    .mcause_i(mcause_i), .pc_i(pc_i), .dmem_addr(dmem_addr), .dmem_ren(dmem_ren),
    .dmem_wen(dmem_wen), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .stall_o(stall_o), .wen_o(wen_o), .rd_o(rd_o),
    .wdata_o(wdata_o), .csr_wen_o(csr_wen_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .exception_o(exception_o), .mcause_o(mcause_o), .pc_o(pc_o)
  );

  always #5 clock = ~clock;

  logic [63:0] mem [0:511];
  always @(posedge clock) begin
    if (dmem_wen)
      for (int b = 0; b < 8; b++)
        if (dmem_wmask[b]) mem[dmem_addr[11:3]][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
    if (dmem_ren) dmem_rdata <= mem[dmem_addr[11:3]];
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic rva, input logic [4:0] f5,
                       input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] sd,
                       input logic wen);
    load_i = ld; store_i = st; rva_valid_i = rva; funct5_i = f5; funct3_i = f3;
    aluout_i = addr; sdata_i = sd; wen_i = wen; rd_i = 5'd1;
    csr_wen_i = 1'b0; csr_addr_i = 12'h0; csr_wdata_i = 64'h0;
    exception_i = 1'b0; mcause_i = 64'h0; pc_i = 64'h1000;
  endtask

  // Issues a load/LR and advances to the cycle where its result is presented.
  task automatic issue_load(input logic [2:0] f3, input logic [63:0] addr, input logic rva,
                            input logic [4:0] f5);
    next(); drive(1'b1, 1'b0, rva, f5, f3, addr, 64'h0, 1'b1);
    @(negedge clock);
    next();
    @(negedge clock);
  endtask

  task automatic issue_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] sd);
    next(); drive(1'b0, 1'b1, 1'b0, 5'b0, f3, addr, sd, 1'b0);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'b0, 3'b011, 64'h80000000, 64'h0, 1'b1);
    @(negedge clock);
    n_cmp++; if (dmem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %b want 0", dmem_ren); end
    n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_o); end
    n_cmp++; if (wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", wen_o); end
    next();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'b0, 3'b0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic test_alu();
    next(); drive(1'b0, 1'b0, 1'b0, 5'b0, 3'b0, 64'hDEAD_BEEF_0000_1234, 64'h0, 1'b1);
    rd_i = 5'd7; csr_wen_i = 1'b1; csr_addr_i = 12'h300; csr_wdata_i = 64'hABC;
    @(negedge clock);
    n_cmp++; if (wdata_o !== 64'hDEAD_BEEF_0000_1234) begin n_fail++; $display("FAIL alu_wdata got %h want deadbeef00001234", wdata_o); end
    n_cmp++; if (wen_o !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_ctl got wen=%b stall=%b want 1 0", wen_o, stall_o); end
    n_cmp++; if (rd_o !== 5'd7 || csr_wen_o !== 1'b1 || csr_addr_o !== 12'h300 || csr_wdata_o !== 64'hABC)
      begin n_fail++; $display("FAIL alu_pass got rd=%0d csr=%b/%h/%h want 7 1/300/abc", rd_o, csr_wen_o, csr_addr_o, csr_wdata_o); end
    n_cmp++; if (dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin n_fail++; $display("FAIL alu_nomem got ren=%b wen=%b want 0 0", dmem_ren, dmem_wen); end
    next(); drive(1'b0, 1'b0, 1'b1, 5'b00101, 3'b011, 64'h55, 64'h0, 1'b1);
    @(negedge clock);
    n_cmp++; if (wdata_o !== 64'h55 || dmem_ren !== 1'b0 || dmem_wen !== 1'b0 || stall_o !== 1'b0)
      begin n_fail++; $display("FAIL bad_f5 got wdata=%h ren=%b wen=%b stall=%b want 55 0 0 0", wdata_o, dmem_ren, dmem_wen, stall_o); end
  endtask

  task automatic test_store_load();
    issue_store(3'b011, 64'h80000010, 64'h1122334455667788);
    n_cmp++; if (dmem_wen !== 1'b1 || dmem_wmask !== 8'hFF || stall_o !== 1'b0)
      begin n_fail++; $display("FAIL sd_ctl got wen=%b mask=%h stall=%b want 1 ff 0", dmem_wen, dmem_wmask, stall_o); end
    n_cmp++; if (dmem_wdata !== 64'h1122334455667788 || dmem_addr !== 64'h80000010)
      begin n_fail++; $display("FAIL sd_data got %h @%h want 1122334455667788 @80000010", dmem_wdata, dmem_addr); end
    next(); drive(1'b1, 1'b0, 1'b0, 5'b0, 3'b000, 64'h80000017, 64'h0, 1'b1);
    @(negedge clock);
    n_cmp++; if (stall_o !== 1'b1 || dmem_ren !== 1'b1 || wen_o !== 1'b0)
      begin n_fail++; $display("FAIL lb_issue got stall=%b ren=%b wen=%b want 1 1 0", stall_o, dmem_ren, wen_o); end
    next();
    @(negedge clock);
    n_cmp++; if (stall_o !== 1'b0 || wen_o !== 1'b1 || wdata_o !== 64'h11)
      begin n_fail++; $display("FAIL lb_b7 got stall=%b wen=%b data=%h want 0 1 11", stall_o, wen_o, wdata_o); end
    issue_load(3'b000, 64'h80000010, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'hFFFFFFFFFFFFFF88) begin n_fail++; $display("FAIL lb_sext got %h want ffffffffffffff88", wdata_o); end
    issue_load(3'b100, 64'h80000010, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h88) begin n_fail++; $display("FAIL lbu got %h want 88", wdata_o); end
    issue_load(3'b001, 64'h80000010, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h7788) begin n_fail++; $display("FAIL lh got %h want 7788", wdata_o); end
    issue_load(3'b011, 64'h80000010, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h1122334455667788) begin n_fail++; $display("FAIL ld got %h want 1122334455667788", wdata_o); end
  endtask

  task automatic test_word_sign();
    issue_store(3'b011, 64'h80000000, 64'h8000000000000000);
    issue_load(3'b010, 64'h80000004, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL lw got %h want ffffffff80000000", wdata_o); end
    issue_load(3'b110, 64'h80000004, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h0000000080000000) begin n_fail++; $display("FAIL lwu got %h want 0000000080000000", wdata_o); end
  endtask

  task automatic test_lr_sc();
    issue_store(3'b011, 64'h100, 64'hAAAA5555AAAA5555);
    issue_load(3'b011, 64'h100, 1'b1, LR);
    n_cmp++; if (wdata_o !== 64'hAAAA5555AAAA5555) begin n_fail++; $display("FAIL lr_data got %h want aaaa5555aaaa5555", wdata_o); end
    next(); drive(1'b0, 1'b0, 1'b1, SC, 3'b011, 64'h100, 64'h55, 1'b1);
    @(negedge clock);
    n_cmp++; if (dmem_wen !== 1'b1 || wdata_o !== 64'h0 || wen_o !== 1'b1 || stall_o !== 1'b0)
      begin n_fail++; $display("FAIL sc_ok got wen=%b rd=%h wen_o=%b stall=%b want 1 0 1 0", dmem_wen, wdata_o, wen_o, stall_o); end
    next(); drive(1'b0, 1'b0, 1'b1, SC, 3'b011, 64'h100, 64'h66, 1'b1);
    @(negedge clock);
    n_cmp++; if (dmem_wen !== 1'b0 || wdata_o !== 64'h1)
      begin n_fail++; $display("FAIL sc_again got wen=%b rd=%h want 0 1", dmem_wen, wdata_o); end
    issue_load(3'b011, 64'h100, 1'b1, LR);
    next(); drive(1'b0, 1'b0, 1'b1, SC, 3'b010, 64'h104, 64'h77, 1'b1);
    @(negedge clock);
    n_cmp++; if (dmem_wen !== 1'b1 || dmem_wmask !== 8'hF0 || dmem_wdata[63:32] !== 32'h77 || wdata_o !== 64'h0)
      begin n_fail++; $display("FAIL scw_gran got wen=%b mask=%h hi=%h rd=%h want 1 f0 77 0", dmem_wen, dmem_wmask, dmem_wdata[63:32], wdata_o); end
    issue_load(3'b011, 64'h100, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h0000007700000055) begin n_fail++; $display("FAIL sc_mem got %h want 0000007700000055", wdata_o); end
  endtask

  task automatic test_amo();
    issue_store(3'b011, 64'h200, 64'h000000007FFFFFFF);
    next(); drive(1'b0, 1'b0, 1'b1, ADD, 3'b010, 64'h200, 64'h1, 1'b1);
    @(negedge clock);
    n_cmp++; if (stall_o !== 1'b1 || dmem_ren !== 1'b1 || wen_o !== 1'b0)
      begin n_fail++; $display("FAIL amo_c1 got stall=%b ren=%b wen=%b want 1 1 0", stall_o, dmem_ren, wen_o); end
    next();
    @(negedge clock);
    n_cmp++; if (stall_o !== 1'b1 || dmem_ren !== 1'b0 || dmem_wen !== 1'b0)
      begin n_fail++; $display("FAIL amo_c2 got stall=%b ren=%b wen=%b want 1 0 0", stall_o, dmem_ren, dmem_wen); end
    next();
    @(negedge clock);
    n_cmp++; if (stall_o !== 1'b0 || dmem_wen !== 1'b1 || dmem_wmask !== 8'h0F || dmem_wdata[31:0] !== 32'h80000000)
      begin n_fail++; $display("FAIL amo_wr got stall=%b wen=%b mask=%h lo=%h want 0 1 0f 80000000", stall_o, dmem_wen, dmem_wmask, dmem_wdata[31:0]); end
    n_cmp++; if (wdata_o !== 64'h000000007FFFFFFF || wen_o !== 1'b1)
      begin n_fail++; $display("FAIL amo_old got %h wen=%b want 000000007fffffff 1", wdata_o, wen_o); end
    issue_load(3'b011, 64'h200, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h0000000080000000) begin n_fail++; $display("FAIL amoadd_mem got %h want 0000000080000000", wdata_o); end
    next(); drive(1'b0, 1'b0, 1'b1, MAX, 3'b010, 64'h200, 64'h5, 1'b1);
    @(negedge clock); next(); @(negedge clock); next(); @(negedge clock);
    n_cmp++; if (wdata_o !== 64'hFFFFFFFF80000000 || dmem_wdata[31:0] !== 32'h5)
      begin n_fail++; $display("FAIL amomax got old=%h new=%h want ffffffff80000000 5", wdata_o, dmem_wdata[31:0]); end
    issue_load(3'b011, 64'h200, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h5) begin n_fail++; $display("FAIL amomax_mem got %h want 5", wdata_o); end
  endtask

  task automatic test_reset_mid();
    issue_store(3'b011, 64'h300, 64'h0123456789ABCDEF);
    issue_load(3'b011, 64'h300, 1'b1, LR);
    next(); drive(1'b0, 1'b0, 1'b1, SWAP, 3'b011, 64'h300, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    @(negedge clock);
    next();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (dmem_wen !== 1'b0 || dmem_ren !== 1'b0 || stall_o !== 1'b0 || wen_o !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid got wen=%b ren=%b stall=%b wen_o=%b want 0 0 0 0", dmem_wen, dmem_ren, stall_o, wen_o); end
    next();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'b0, 3'b0, 64'h0, 64'h0, 1'b0);
    @(negedge clock);
    n_cmp++; if (stall_o !== 1'b0 || dmem_wen !== 1'b0) begin n_fail++; $display("FAIL rst_idle got stall=%b wen=%b want 0 0", stall_o, dmem_wen); end
    next(); drive(1'b0, 1'b0, 1'b1, SC, 3'b011, 64'h300, 64'h42, 1'b1);
    @(negedge clock);
    n_cmp++; if (wdata_o !== 64'h1 || dmem_wen !== 1'b0) begin n_fail++; $display("FAIL rst_resv got rd=%h wen=%b want 1 0", wdata_o, dmem_wen); end
    issue_load(3'b011, 64'h300, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rst_mem got %h want 0123456789abcdef", wdata_o); end
  endtask

  task automatic test_exception();
    issue_load(3'b011, 64'h100, 1'b1, LR);
    next(); drive(1'b1, 1'b0, 1'b0, 5'b0, 3'b011, 64'h100, 64'h0, 1'b1);
    exception_i = 1'b1; mcause_i = 64'd5; csr_wen_i = 1'b1;
    @(negedge clock);
    n_cmp++; if (dmem_ren !== 1'b0 || stall_o !== 1'b0 || wen_o !== 1'b0 || csr_wen_o !== 1'b0)
      begin n_fail++; $display("FAIL exc_ctl got ren=%b stall=%b wen=%b csr=%b want 0 0 0 0", dmem_ren, stall_o, wen_o, csr_wen_o); end
    n_cmp++; if (exception_o !== 1'b1 || mcause_o !== 64'd5 || pc_o !== 64'h1000)
      begin n_fail++; $display("FAIL exc_pass got exc=%b cause=%h pc=%h want 1 5 1000", exception_o, mcause_o, pc_o); end
    next(); drive(1'b0, 1'b0, 1'b1, SC, 3'b011, 64'h100, 64'h99, 1'b1);
    @(negedge clock);
    n_cmp++; if (wdata_o !== 64'h1 || dmem_wen !== 1'b0) begin n_fail++; $display("FAIL exc_resv got rd=%h wen=%b want 1 0", wdata_o, dmem_wen); end
  endtask

  task automatic test_misalign();
    issue_store(3'b010, 64'h202, 64'hCAFEBABE);
`ifdef MEM_MISALIGN_CHECK_EN
    n_cmp++; if (exception_o !== 1'b1 || mcause_o !== 64'd6 || dmem_wen !== 1'b0 || pc_o !== 64'h1000)
      begin n_fail++; $display("FAIL mis_sw got exc=%b cause=%h wen=%b pc=%h want 1 6 0 1000", exception_o, mcause_o, dmem_wen, pc_o); end
    next(); drive(1'b1, 1'b0, 1'b0, 5'b0, 3'b010, 64'h201, 64'h0, 1'b1);
    @(negedge clock);
    n_cmp++; if (exception_o !== 1'b1 || mcause_o !== 64'd4 || dmem_ren !== 1'b0 || stall_o !== 1'b0 || wen_o !== 1'b0)
      begin n_fail++; $display("FAIL mis_lw got exc=%b cause=%h ren=%b stall=%b wen=%b want 1 4 0 0 0", exception_o, mcause_o, dmem_ren, stall_o, wen_o); end
`else
    n_cmp++; if (dmem_wen !== 1'b1 || dmem_wmask !== 8'h3C || dmem_wdata[47:16] !== 32'hCAFEBABE)
      begin n_fail++; $display("FAIL mis_sw got wen=%b mask=%h lanes=%h want 1 3c cafebabe", dmem_wen, dmem_wmask, dmem_wdata[47:16]); end
    issue_load(3'b011, 64'h200, 1'b0, 5'b0);
    n_cmp++; if (wdata_o !== 64'h0000CAFEBABE0005) begin n_fail++; $display("FAIL mis_mem got %h want 0000cafebabe0005", wdata_o); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_word_sign();
    test_lr_sc();
    test_amo();
    test_reset_mid();
    test_exception();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
